// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NCH independent programmable clock dividers.
//
// Each channel produces a registered divided clock with a programmable
// half-period (hp). It can also be realigned by a shared sync strobe.
// Half-period updates go through a one-deep pending register. On a
// running channel the pending value is applied only at a toggle or
// sync edge, so the output never glitches.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   en       - per-channel run enable
//   sync     - one-cycle realign strobe (cnt=0, out=0 on enabled channels)
//   div_wr   - one-cycle half-period write strobe
//   div_ch   - target channel for div_wr
//   div_val  - requested half-period in clk cycles
//   div_out  - divided clocks
//   tick     - one-cycle pulse after each div_out rising edge
//   div_busy - a write is pending on the channel
//   div_ack  - one-cycle pulse when a pending value takes effect
//   div_err  - one-cycle pulse for a rejected write (zero value / bad channel)
module clk_div_bank #(
    parameter int NCH    = 2,
    parameter int CW     = 8,
    parameter int DEF_HP = 2,
    parameter int CHW    = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           div_wr,
    input  logic [CHW-1:0] div_ch,
    input  logic [CW-1:0]  div_val,
    output logic [NCH-1:0] div_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] div_busy,
    output logic [NCH-1:0] div_ack,
    output logic           div_err
);

    logic wr_bad;
    logic wr_ok;

    assign wr_bad = div_wr && ((div_val == '0) || (32'(div_ch) >= NCH));
    assign wr_ok  = div_wr && !wr_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_err <= 1'b0;
        else     div_err <= wr_bad;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] hp;
        logic [CW-1:0] cnt;
        logic [CW-1:0] pend;
        logic          pend_v;
        logic          out_r;
        logic          tick_r;
        logic          ack_r;
        logic          hit;
        logic          wrap;
        logic          apply;

        assign hit  = wr_ok && (32'(div_ch) == i);
        assign wrap = (cnt == hp - CW'(1));
        // Safe apply points: a disabled channel (nothing to glitch), a
        // sync edge, or the edge where the output toggles anyway.
        assign apply = pend_v && (!en[i] || sync || wrap);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hp     <= CW'(DEF_HP);
                cnt    <= '0;
                pend   <= '0;
                pend_v <= 1'b0;
                out_r  <= 1'b0;
                tick_r <= 1'b0;
                ack_r  <= 1'b0;
            end else begin
                tick_r <= 1'b0;
                if (!en[i] || sync) begin
                    cnt   <= '0;
                    out_r <= 1'b0;
                end else if (wrap) begin
                    cnt    <= '0;
                    out_r  <= ~out_r;
                    tick_r <= ~out_r;
                end else begin
                    cnt <= cnt + CW'(1);
                end

                ack_r <= apply;
                if (apply) hp <= pend;

                // A write landing on an apply edge becomes the next pending value.
                if (hit) begin
                    pend   <= div_val;
                    pend_v <= 1'b1;
                end else if (apply) begin
                    pend_v <= 1'b0;
                end
            end
        end

        assign div_out[i]  = out_r;
        assign tick[i]     = tick_r;
        assign div_ack[i]  = ack_r;
        assign div_busy[i] = pend_v;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank. A phase-based reference model
// predicts every output each cycle. Directed literal checks pin the
// model, and a randomized phase follows.
module tb_clk_div_bank;
    localparam int NCH    = 3;
    localparam int CW     = 8;
    localparam int DEF_HP = 2;
    localparam int CHW    = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] en = '0;
    logic           sync = 1'b0;
    logic           div_wr = 1'b0;
    logic [CHW-1:0] div_ch = '0;
    logic [CW-1:0]  div_val = '0;
    logic [NCH-1:0] div_out, tick, div_busy, div_ack;
    logic           div_err;

    clk_div_bank #(.NCH(NCH), .CW(CW), .DEF_HP(DEF_HP), .CHW(CHW)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .div_wr(div_wr),
        .div_ch(div_ch), .div_val(div_val), .div_out(div_out), .tick(tick),
        .div_busy(div_busy), .div_ack(div_ack), .div_err(div_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a phase counter t, counted from the
    // last realign point. The output is base ^ floor(t/hp) mod 2.
    int m_t[NCH], m_hp[NCH], m_base[NCH], m_pv[NCH], m_pend[NCH];
    logic [NCH-1:0] x_out = '0, x_tick = '0, x_ack = '0;
    logic           x_err = 1'b0;

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_t[i] = 0; m_hp[i] = DEF_HP; m_base[i] = 0; m_pv[i] = 0; m_pend[i] = 0;
        end
        x_out = '0; x_tick = '0; x_ack = '0; x_err = 1'b0;
    endtask

    initial m_reset();

    always @(posedge clk) begin
        if (rst) begin
            m_reset();
        end else begin
            x_err = div_wr && (div_val == 0 || div_ch >= NCH);
            for (int i = 0; i < NCH; i++) begin
                int o;
                bit tog, app, hit;
                hit = div_wr && div_val != 0 && div_ch < NCH && div_ch == i;
                tog = 0;
                if (!en[i] || sync) begin
                    m_t[i] = 0; m_base[i] = 0; app = (m_pv[i] != 0);
                end else begin
                    m_t[i]++;
                    tog = (m_t[i] % m_hp[i]) == 0;
                    app = tog && (m_pv[i] != 0);
                end
                o = m_base[i] ^ ((m_t[i] / m_hp[i]) % 2);
                x_tick[i] = tog && (o == 1);
                x_ack[i]  = app;
                x_out[i]  = o[0];
                if (app) begin
                    m_hp[i] = m_pend[i]; m_base[i] = o; m_t[i] = 0; m_pv[i] = 0;
                end
                if (hit) begin
                    m_pend[i] = div_val; m_pv[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NCH-1:0] x_busy;
        for (int i = 0; i < NCH; i++) x_busy[i] = (m_pv[i] != 0);
        chk("div_out", 32'(div_out), 32'(x_out));
        chk("tick", 32'(tick), 32'(x_tick));
        chk("div_busy", 32'(div_busy), 32'(x_busy));
        chk("div_ack", 32'(div_ack), 32'(x_ack));
        chk("div_err", 32'(div_err), 32'(x_err));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int acks;
        cyc(3);
        chk("rst_out", 32'(div_out), 0);
        chk("rst_busy", 32'(div_busy), 0);

        // Defaults: period 4, the first rise comes 2 edges after enable.
        rst = 1'b0; en = 3'b011;
        cyc(2);
        chk("first_rise", 32'(div_out[1:0]), 32'h3);
        chk("first_tick", 32'(tick), 32'h3);
        cyc(1);
        chk("tick_pulse", 32'(tick), 0);
        cyc(1);
        chk("fall", 32'(div_out[1:0]), 0);
        cyc(2);
        chk("second_rise", 32'(div_out[1:0]), 32'h3);
        chk("second_tick", 32'(tick), 32'h3);

        // Write ch1 mid half-period; it applies at the next toggle.
        div_wr = 1'b1; div_ch = 2'd1; div_val = 8'd5;
        cyc(1);
        div_wr = 1'b0;
        chk("busy_ch1", 32'(div_busy), 32'h2);
        cyc(1);
        chk("ack_ch1", 32'(div_ack), 32'h2);
        chk("busy_clr", 32'(div_busy), 0);

        // Rejected writes.
        div_wr = 1'b1; div_ch = 2'd0; div_val = 8'd0;
        cyc(1);
        div_wr = 1'b0;
        chk("err_zero", 32'(div_err), 1);
        chk("err_zero_busy", 32'(div_busy), 0);
        cyc(1);
        chk("err_clear", 32'(div_err), 0);
        div_wr = 1'b1; div_ch = 2'd3; div_val = 8'd4;
        cyc(1);
        div_wr = 1'b0;
        chk("err_ch", 32'(div_err), 1);
        chk("err_ch_busy", 32'(div_busy), 0);

        // Sync plus two back-to-back writes to ch0: a single ack.
        sync = 1'b1; div_wr = 1'b1; div_ch = 2'd0; div_val = 8'd4;
        cyc(1);
        chk("sync_out", 32'(div_out), 0);
        sync = 1'b0; div_val = 8'd7;
        cyc(1);
        div_wr = 1'b0;
        acks = 0;
        repeat (8) begin
            cyc(1);
            acks += int'(div_ack[0]);
        end
        chk("single_ack", 32'(acks), 1);

        // Reset discards a pending write.
        div_wr = 1'b1; div_ch = 2'd1; div_val = 8'd9;
        cyc(1);
        div_wr = 1'b0;
        chk("pend_before_rst", 32'(div_busy), 32'h2);
        rst = 1'b1;
        #1 chk("async_rst_out", 32'(div_out), 0);
        cyc(1);
        chk("rst_busy2", 32'(div_busy), 0);
        chk("rst_ack", 32'(div_ack), 0);
        rst = 1'b0;
        cyc(20);

        // Randomized phase.
        repeat (3000) begin
            cyc(1);
            rst     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) en = NCH'($urandom);
            sync    = ($urandom_range(0, 29) == 0);
            div_wr  = ($urandom_range(0, 3) == 0);
            div_ch  = CHW'($urandom);
            div_val = CW'($urandom_range(0, 6));
        end
        rst = 1'b0; div_wr = 1'b0; sync = 1'b0;
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
